// File: rtl/pp_job_scheduler.sv
// Round-robin scheduler sharing one packet-processing engine among NUM_REQ
// requesters; launches one job at a time and returns engine or watchdog status.
module pp_job_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   input  logic [NUM_REQ*32-1:0] req_addr_i,
   input  logic [NUM_REQ-1:0]    req_ign_ecc_i,
   output logic                  pp_start_o,
   output logic [31:0]           pp_addr_hdr_o,
   output logic                  pp_ignore_ecc_err_o,
   input  logic                  pp_busy_i,
   input  logic                  pp_irq_i,
   input  logic                  pp_ecc_corr_i,
   input  logic                  pp_ecc_uncorr_i,
   input  logic                  pp_crc_err_i,
   input  logic [3:0]            pp_byte_cnt_i,
   input  logic [3:0]            pp_type_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [ID_W-1:0]       rsp_id_o,
   output logic [11:0]           rsp_status_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam int PW    = ID_W + 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   id_q;
   logic [31:0]       addr_q;
   logic              ign_q;
   logic [CNT_W-1:0]  cnt;
   logic [11:0]       status_q;

   logic [PW-1:0]     scan_idx;
   logic              grant_found;
   logic [ID_W-1:0]   grant_id;
   logic              accept;
   logic              timeout_hit;

   // Scan upward from rr_ptr with wrap; the first pending requester wins.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      grant_found = 1'b0;
      grant_id    = '0;
      scan_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = {1'b0, rr_ptr} + PW'(i);
         if (scan_idx >= PW'(NUM_REQ))
            scan_idx = scan_idx - PW'(NUM_REQ);
         if (!grant_found && req_valid_i[scan_idx[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = scan_idx[ID_W-1:0];
         end
      end
   end

   // Gating on reset keeps a requester from seeing an accept the FSM then discards.
   assign accept      = (state == IDLE) && !pp_busy_i && grant_found && !reset;
   assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = LAUNCH;
         LAUNCH:  state_nxt = RUN;
         RUN:     if (pp_irq_i || timeout_hit) state_nxt = RESP;
         RESP:    if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = accept ? (NUM_REQ'(1) << grant_id) : '0;
      pp_start_o  = (state == LAUNCH) && !reset;
      rsp_valid_o = (state == RESP) && !reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr   <= '0;
         id_q     <= '0;
         addr_q   <= '0;
         ign_q    <= 1'b0;
         cnt      <= '0;
         status_q <= '0;
      end else begin
         if (accept) begin
            addr_q <= req_addr_i[{grant_id, 5'b0} +: 32];
            ign_q  <= req_ign_ecc_i[grant_id];
            id_q   <= grant_id;
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
         end
         if (state == LAUNCH)
            cnt <= '0;
         else if (state == RUN)
            cnt <= cnt + 1'b1;
         // An irq in the timeout cycle still reports the engine's status.
         if (state == RUN) begin
            if (pp_irq_i)
               status_q <= {1'b0, pp_ecc_corr_i, pp_ecc_uncorr_i, pp_crc_err_i,
                            pp_byte_cnt_i, pp_type_i};
            else if (timeout_hit)
               status_q <= 12'h800;
         end
      end
   end

   assign pp_addr_hdr_o       = addr_q;
   assign pp_ignore_ecc_err_o = ign_q;
   assign rsp_id_o            = id_q;
   assign rsp_status_o        = status_q;

endmodule

// File: doc/pp_job_scheduler.md
Name: pp_job_scheduler

Overview:
- Round-robin scheduler that shares one packet-processing engine (start/busy/irq plus status interface) among NUM_REQ job requesters.
- Accepts a job (header address, ignore-ECC flag) from one requester and launches the engine with a single-cycle start pulse.
- Waits for the engine completion interrupt, with a watchdog timeout, then returns captured status tagged with the requester ID.
- Sits between the host/job queues and the packet builder/parser engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), requester ID width.
- TIMEOUT_CYC, 1024, RUN-state cycles without irq before the job is aborted (>=2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester job request.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_addr_i  in  NUM_REQ*32  header address; requester k uses bits [32k+31:32k].
- req_ign_ecc_i  in  NUM_REQ  per-requester ignore-ECC-error flag.
- pp_start_o  out  1  engine start pulse.
- pp_addr_hdr_o  out  32  header address to the engine.
- pp_ignore_ecc_err_o  out  1  ignore-ECC flag to the engine.
- pp_busy_i  in  1  engine busy.
- pp_irq_i  in  1  engine done interrupt.
- pp_ecc_corr_i, pp_ecc_uncorr_i, pp_crc_err_i  in  1 each  engine status flags.
- pp_byte_cnt_i  in  4  engine byte count.
- pp_type_i  in  4  engine packet type.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accept.
- rsp_id_o  out  ID_W  ID of the requester that owns the response.
- rsp_status_o  out  12  status word: [3:0] type, [7:4] byte_cnt, [8] crc_err, [9] ecc_uncorr, [10] ecc_corr, [11] timeout.

Behaviour:
- FSM states: IDLE, LAUNCH, RUN, RESP.
- Reset: state=IDLE, rr_ptr=0, timeout counter=0, all outputs 0 (req_ready_o, pp_start_o, pp_addr_hdr_o, pp_ignore_ecc_err_o, rsp_valid_o, rsp_id_o, rsp_status_o).
- Reset mid-job returns to IDLE immediately and drops the pending response. The engine is not notified; any irq that arrives while in IDLE is ignored.

IDLE:
- Arbitration is combinational. Search req_valid_i starting at index rr_ptr, upward with wrap; the first set bit is the grant g.
- req_ready_o[g]=1 only when state=IDLE and pp_busy_i=0. No grant is made while the engine is busy.
- When a grant is made: latch addr, ignore flag and id=g; set rr_ptr <= (g+1) mod NUM_REQ; next state LAUNCH.

LAUNCH:
- pp_start_o=1 for exactly this cycle.
- pp_addr_hdr_o and pp_ignore_ecc_err_o are driven from latched values; they are valid from LAUNCH and held stable through RUN.
- Clear the timeout counter; next state RUN.

RUN:
- pp_start_o=0. The counter increments each cycle.
- If pp_irq_i=1: capture type, byte_cnt, crc_err, ecc_uncorr and ecc_corr into rsp_status_o, with timeout bit=0; next state RESP.
- Else if counter == TIMEOUT_CYC-1: rsp_status_o = 12'h800 (timeout only); next state RESP.
- If irq and timeout occur in the same cycle, irq wins.
- irq is sampled only in RUN.

RESP:
- rsp_valid_o=1, with rsp_id_o and rsp_status_o stable until rsp_ready_i=1. On that cycle: next state IDLE, rsp_valid_o=0 from the next cycle.

Latency and ordering:
- Handshake in cycle T: pp_start_o in T+1; irq seen in cycle U gives rsp_valid_o in U+1.
- Earliest next grant is the cycle after the response handshake. There is no back-to-back overlap and at most one job is in flight.
- req_ready_o is never asserted outside IDLE, so the requester must hold req_valid_i and its data until accepted.

Test Plan:
- Single job: req_valid_i=4'b0100, addr=32'hBABABABA, ign=1; irq 5 cycles after start with type=4'h3, byte_cnt=4'h9, crc_err=1 -> req_ready_o=4'b0100 for 1 cycle; pp_start_o pulses once with pp_addr_hdr_o=32'hBABABABA; rsp_id_o=2, rsp_status_o=12'h193.
- Round-robin: all four requesters valid continuously, immediate irq and rsp_ready_i -> grant order 0,1,2,3,0; each requester accepted exactly once per 4 jobs.
- Timeout: no irq after start -> rsp_valid_o exactly TIMEOUT_CYC cycles after entering RUN, rsp_status_o=12'h800; next job is granted normally afterwards.
- Busy gating and backpressure: pp_busy_i=1 in IDLE with req pending -> no req_ready_o until busy drops. Hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o, rsp_id_o and rsp_status_o stable, no new grant.
- Boundary: irq and timeout in the same cycle -> status taken from the engine, bit 11=0.
- Reset mid-job: assert reset during RUN, then irq after reset -> all outputs 0, no rsp_valid_o, and the next grant starts from index 0.
